// File: rtl/or_pkg.sv
// Shared widths and types for the Or8Way gate and its clocked side outputs.
package or_pkg;

  // Default (and supported) number of bits reduced.
  localparam int DEF_WIDTH = 8;

  // Width needed to hold an index into a vector of w bits.
  function automatic int idx_width(input int w);
    return $clog2(w);
  endfunction

  // Width needed to hold a population count of w bits (0..w inclusive).
  // The extra bit covers the all-ones case, where the count equals w.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int IDX_W = idx_width(DEF_WIDTH);
  localparam int CNT_W = cnt_width(DEF_WIDTH);

  typedef logic [DEF_WIDTH-1:0] or_vec_t;

endpackage : or_pkg

// File: rtl/or_tree.sv
// Balanced binary tree of 2-input ORs reducing WIDTH bits to one.
// Non-power-of-two widths are padded with constant zeros at the leaves.
// Purely combinational; X on one input is masked by a 1 on another.
module or_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);

  localparam int LEVELS = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam int PAD    = 1 << LEVELS;

  genvar gi, gj;

  // Level 0 holds the (padded) leaves; each higher level halves the width.
  for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
    localparam int N = PAD >> gi;
    logic [N-1:0] v;

    if (gi == 0) begin : g_leaf
      for (gj = 0; gj < N; gj++) begin : g_bit
        if (gj < WIDTH) begin : g_real
          assign v[gj] = in[gj];
        end else begin : g_pad
          assign v[gj] = 1'b0;
        end
      end
    end else begin : g_node
      for (gj = 0; gj < N; gj++) begin : g_bit
        assign v[gj] = g_lvl[gi-1].v[2*gj] | g_lvl[gi-1].v[2*gj+1];
      end
    end
  end

  assign out = g_lvl[LEVELS].v[0];

endmodule : or_tree

// File: rtl/or_8_way.sv
// Or8Way gate: combinational OR reduction of in, plus registered copies
// (OR, lowest-set-bit index, popcount) and a sticky "seen a one" flag.
module or_8_way
  import or_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          out,
  input  logic [WIDTH-1:0]              in,
  input  logic                          clr,
  output logic                          out_q,
  output logic [idx_width(WIDTH)-1:0]   idx_q,
  output logic [cnt_width(WIDTH)-1:0]   cnt_q,
  output logic                          sticky
);

  localparam int IW = idx_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  logic          any_one;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] cnt_next;
  logic          sticky_next;

  // Zero-latency reduction; not touched by clk or rst.
  or_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .in  (in),
    .out (any_one)
  );

  assign out = any_one;

  // Lowest set bit: scan from the top down so the lowest index written last wins.
  // An all-zero input leaves the default of 0; out_q tells it apart from bit 0.
  always_comb begin
    idx_next = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx_next = IW'(i);
      end
    end
  end

  // Population count of the input vector.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CW'(in[i]);
    end
  end

  // Sticky flag: clear dominates a simultaneous set, otherwise set on any one.
  always_comb begin
    sticky_next = sticky;
    if (clr) begin
      sticky_next = 1'b0;
    end else if (any_one) begin
      sticky_next = 1'b1;
    end
  end

  // Clocked copies; reset clears them immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      sticky <= 1'b0;
    end else begin
      out_q  <= any_one;
      idx_q  <= idx_next;
      cnt_q  <= cnt_next;
      sticky <= sticky_next;
    end
  end

endmodule : or_8_way

// File: tb/tb_or_8_way.sv
// Directed-vector bench for or_8_way with hand-computed expectations.
module tb_or_8_way;

  logic       clk;
  logic       rst;
  logic       out;
  logic [7:0] in;
  logic       clr;
  logic       out_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic       sticky;

  int n_checks = 0;
  int n_errors = 0;

  or_8_way dut (
    .clk    (clk),
    .rst    (rst),
    .out    (out),
    .in     (in),
    .clr    (clr),
    .out_q  (out_q),
    .idx_q  (idx_q),
    .cnt_q  (cnt_q),
    .sticky (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one vector mid-cycle, check the combinational output, then the
  // registered outputs just after the next rising edge.
  task automatic apply(input logic [7:0] v, input logic c,
                       input logic e_out, input logic [2:0] e_idx,
                       input logic [3:0] e_cnt, input logic e_sticky);
    @(negedge clk);
    in  = v;
    clr = c;
    #1;
    check("out", 32'(out), 32'(e_out));
    @(posedge clk);
    #1;
    check("out_q",  32'(out_q),  32'(e_out));
    check("idx_q",  32'(idx_q),  32'(e_idx));
    check("cnt_q",  32'(cnt_q),  32'(e_cnt));
    check("sticky", 32'(sticky), 32'(e_sticky));
    $display("in=%b clr=%b -> out=%b out_q=%b idx_q=%0d cnt_q=%0d sticky=%b",
             v, c, out, out_q, idx_q, cnt_q, sticky);
  endtask

  initial begin
    rst = 1'b1;
    in  = 8'h00;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_q",  32'(out_q),  32'd0);
    check("rst_idx_q",  32'(idx_q),  32'd0);
    check("rst_cnt_q",  32'(cnt_q),  32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_out",    32'(out),    32'd0);

    @(negedge clk);
    rst = 1'b0;

    //      in            clr   out   idx   cnt   sticky
    apply(8'b0000_0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    apply(8'b0000_0010, 1'b0, 1'b1, 3'd1, 4'd1, 1'b1);
    apply(8'b0001_0111, 1'b0, 1'b1, 3'd0, 4'd4, 1'b1);
    apply(8'b1111_1111, 1'b0, 1'b1, 3'd0, 4'd8, 1'b1);
    apply(8'b1000_0000, 1'b0, 1'b1, 3'd7, 4'd1, 1'b1);
    apply(8'b0010_1000, 1'b0, 1'b1, 3'd3, 4'd2, 1'b1);
    apply(8'b0110_0000, 1'b0, 1'b1, 3'd5, 4'd2, 1'b1);
    // sticky clear, then clear winning over a simultaneous set
    apply(8'b0000_0000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    apply(8'b1000_0000, 1'b1, 1'b1, 3'd7, 4'd1, 1'b0);
    apply(8'b0000_0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    apply(8'b0000_0100, 1'b0, 1'b1, 3'd2, 4'd1, 1'b1);
    apply(8'b0000_0000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);

    // OR dominance over unknown bits
    @(negedge clk);
    in = 8'bxxxx_x1xx;
    #1;
    check("x_dom_out", 32'(out), 32'd1);
    $display("in=%b -> out=%b", in, out);

    // asynchronous reset mid-run with in=FF
    apply(8'b1111_1111, 1'b0, 1'b1, 3'd0, 4'd8, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_q",  32'(out_q),  32'd0);
    check("arst_idx_q",  32'(idx_q),  32'd0);
    check("arst_cnt_q",  32'(cnt_q),  32'd0);
    check("arst_sticky", 32'(sticky), 32'd0);
    check("arst_out",    32'(out),    32'd1);
    $display("async rst: out=%b out_q=%b cnt_q=%0d sticky=%b", out, out_q, cnt_q, sticky);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_hold", 32'(cnt_q), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_out_q",  32'(out_q),  32'd1);
    check("post_rst_cnt_q",  32'(cnt_q),  32'd8);
    check("post_rst_sticky", 32'(sticky), 32'd1);
    $display("after rst release: out_q=%b cnt_q=%0d sticky=%b", out_q, cnt_q, sticky);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_or_8_way
